seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal values 8, 16, 32 and 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width in bits.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 a, b  in  WIDTH each  operands.
REQ-008 sel  in  6  operation select (encodings in REQ-017).
REQ-009 imm  in  WIDTH  sign-extended branch offset.
REQ-010 pc  in  WIDTH  program counter.
REQ-011 out_valid  out  1  result outputs valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 result  out  WIDTH  primary result; for MULU, the product low half; for DIVU, the quotient.
REQ-014 result_hi  out  WIDTH  MULU: product high half; DIVU: remainder; all other ops: 0.
REQ-015 zero_flag, ovf_flag, dz_flag, illegal  out  1 each  status flags (REQ-020 to REQ-023).
REQ-016 branch_target  out  WIDTH  (imm << 2) + pc, modulo 2^WIDTH.

Function
REQ-017 sel encodings:
- 000000 ADD; 000001 SUB; 000010 AND; 000011 OR
- 000100 SLL; 000101 SRL; 000110 SLT (signed); 000111 SLTU
- 001000 SRA; 001001 XOR; 001010 NOR
- 001011 MULU; 001100 DIVU; 111111 NOP (result 0)
REQ-018 Shift ops SHALL use only b[SHW-1:0] as the shift amount; SRA SHALL replicate a[WIDTH-1].
REQ-019 SLT/SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-020 zero_flag SHALL be (a==b), using the operands captured at accept, for every op except NOP; for NOP it SHALL be 0.
REQ-021 ovf_flag SHALL be signed two's-complement overflow for ADD/SUB; 0 for all other ops.
REQ-022 dz_flag SHALL be 1 only for DIVU with b==0; in that case result = all ones and result_hi = a.
REQ-023 illegal SHALL be 1 for any unlisted sel; result, result_hi and the other flags SHALL then be 0.
REQ-024 FSM states: IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-025 Accept SHALL occur when in_valid and in_ready are both 1; a, b, sel, imm and pc SHALL be registered at accept.
REQ-026 IDLE with an accepted single-cycle op (any op except MULU/DIVU, including illegal) SHALL go to DONE; outputs valid the next cycle, so latency is 1.
REQ-027 IDLE with accepted MULU or DIVU:
- move to BUSY and load the iteration counter with WIDTH
- BUSY performs one shift-add (MULU) or restoring-subtract (DIVU) step per cycle and decrements the counter
- on counter reaching 0, move to DONE
- latency is WIDTH+1 cycles from accept to out_valid
REQ-028 DIVU with b==0 SHALL skip BUSY and reach DONE with latency 1.
REQ-029 In DONE, out_valid = 1, and all outputs SHALL hold stable until out_ready = 1; on that edge the FSM returns to IDLE.
REQ-030 Result and flag outputs SHALL be registered, with no combinational path from a, b or sel to any output.
REQ-031 A back-to-back issue SHALL be possible on the cycle after DONE exits, giving 1 result per 2 cycles for single-cycle ops.
REQ-032 in_valid while BUSY or DONE SHALL be ignored; the requester holds the request until in_ready.
REQ-033 MULU SHALL be unsigned WIDTH x WIDTH producing 2*WIDTH bits; DIVU SHALL be unsigned.

Reset
REQ-034 rst sampled high SHALL, in any state including mid-BUSY, force:
- FSM state to IDLE; counter to 0
- in_ready = 1 and out_valid = 0
- all results, flags and branch_target to 0
- any in-flight operation discarded
REQ-035 rst SHALL take priority over accept in the same cycle.

Verification
REQ-036 ADD a=0x7FFFFFFF, b=1 -> after 1 cycle: result=0x80000000, ovf_flag=1, zero_flag=0.
REQ-037 MULU a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after accept; result=0xFFFFFFFE, result_hi=0x00000001.
REQ-038 DIVU a=100, b=7 -> result=14, result_hi=2 after 33 cycles; DIVU a=5, b=0 -> 1 cycle later, result=0xFFFFFFFF, result_hi=5, dz_flag=1.
REQ-039 SRA a=0x80000000, b=0x24 (shift 4) -> result=0xF8000000; SLT a=-1, b=1 -> 1; SLTU a=-1, b=1 -> 0.
REQ-040 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; assert rst at BUSY cycle 10 -> next cycle in IDLE with out_valid=0 and all outputs 0.
REQ-041 imm=3, pc=0x100 -> branch_target=0x10C; sel=0x3E -> illegal=1, result=0.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), behind a valid/ready handshake.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       sel,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero_flag,
   output logic             ovf_flag,
   output logic             dz_flag,
   output logic             illegal,
   output logic [WIDTH-1:0] branch_target
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int M  = WIDTH - 1;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_AND  = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b000011;
   localparam logic [5:0] OP_SLL  = 6'b000100;
   localparam logic [5:0] OP_SRL  = 6'b000101;
   localparam logic [5:0] OP_SLT  = 6'b000110;
   localparam logic [5:0] OP_SLTU = 6'b000111;
   localparam logic [5:0] OP_SRA  = 6'b001000;
   localparam logic [5:0] OP_XOR  = 6'b001001;
   localparam logic [5:0] OP_NOR  = 6'b001010;
   localparam logic [5:0] OP_MULU = 6'b001011;
   localparam logic [5:0] OP_DIVU = 6'b001100;
   localparam logic [5:0] OP_NOP  = 6'b111111;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [5:0]       r_sel;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_zero;
   logic             w_ovf;
   logic             w_dz;
   logic             w_ill;
   logic             w_long;

   logic [WIDTH:0]   w_madd;
   logic [WIDTH:0]   w_rs;
   logic [WIDTH:0]   w_rsub;
   logic             w_ge;
   logic             w_is_div;
   logic [WIDTH-1:0] w_hi_nx;
   logic [WIDTH-1:0] w_lo_nx;

   // Single-cycle result and flags, evaluated from the request being accepted
   always_comb begin
      w_res  = '0;
      w_hi   = '0;
      w_ovf  = 1'b0;
      w_dz   = 1'b0;
      w_ill  = 1'b0;
      w_zero = (a == b);
      w_sum  = a + b;
      w_diff = a - b;
      case (sel)
         OP_ADD: begin
            w_res = w_sum;
            w_ovf = (a[M] == b[M]) && (w_sum[M] != a[M]);
         end
         OP_SUB: begin
            w_res = w_diff;
            w_ovf = (a[M] != b[M]) && (w_diff[M] != a[M]);
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_SLL:  w_res = a << b[SHW-1:0];
         OP_SRL:  w_res = a >> b[SHW-1:0];
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SRA:  w_res = $unsigned($signed(a) >>> b[SHW-1:0]);
         OP_XOR:  w_res = a ^ b;
         OP_NOR:  w_res = ~(a | b);
         OP_MULU: w_res = '0;
         OP_DIVU: begin
            // Divide by zero finishes immediately with a saturated quotient
            if (b == '0) begin
               w_res = '1;
               w_hi  = a;
               w_dz  = 1'b1;
            end
         end
         OP_NOP:  w_zero = 1'b0;
         default: begin
            w_ill  = 1'b1;
            w_zero = 1'b0;
         end
      endcase
      w_long = (sel == OP_MULU) || ((sel == OP_DIVU) && (b != '0));
   end

   // One iteration of shift-add multiply or restoring divide on {r_hi, r_lo}
   always_comb begin
      w_is_div = (r_sel == OP_DIVU);
      w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
      w_rs     = {r_hi, r_lo[WIDTH-1]};
      w_rsub   = w_rs - {1'b0, r_b};
      // Remainder stays below the divisor, so the top bit is the borrow
      w_ge     = ~w_rsub[WIDTH];
      if (w_is_div) begin
         w_hi_nx = w_ge ? w_rsub[WIDTH-1:0] : w_rs[WIDTH-1:0];
         w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
      end else begin
         w_hi_nx = w_madd[WIDTH:1];
         w_lo_nx = {w_madd[0], r_lo[WIDTH-1:1]};
      end
   end

   // Control FSM with registered handshake, results and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_a           <= '0;
         r_b           <= '0;
         r_sel         <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         result        <= '0;
         result_hi     <= '0;
         zero_flag     <= 1'b0;
         ovf_flag      <= 1'b0;
         dz_flag       <= 1'b0;
         illegal       <= 1'b0;
         branch_target <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  r_a           <= a;
                  r_b           <= b;
                  r_sel         <= sel;
                  branch_target <= (imm << 2) + pc;
                  zero_flag     <= w_zero;
                  ovf_flag      <= w_ovf;
                  dz_flag       <= w_dz;
                  illegal       <= w_ill;
                  in_ready      <= 1'b0;
                  if (w_long) begin
                     r_hi      <= '0;
                     r_lo      <= (sel == OP_DIVU) ? a : b;
                     r_cnt     <= CW'(WIDTH);
                     result    <= '0;
                     result_hi <= '0;
                     r_state   <= S_BUSY;
                  end else begin
                     result    <= w_res;
                     result_hi <= w_hi;
                     out_valid <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end
            end
            S_BUSY: begin
               r_hi  <= w_hi_nx;
               r_lo  <= w_lo_nx;
               r_cnt <= r_cnt - 1'b1;
               // Last step: low half is product-low / quotient, high half is product-high / remainder
               if (r_cnt == CW'(1)) begin
                  result    <= w_lo_nx;
                  result_hi <= w_hi_nx;
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations are queued at issue and
// popped when the DUT presents a result.
module tb_seq_alu;

   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0, b = '0, imm = '0, pc = '0;
   logic [5:0]   sel = '0;
   logic         in_ready, out_valid, zero_flag, ovf_flag, dz_flag, illegal;
   logic [W-1:0] result, result_hi, branch_target;

   int checks = 0;
   int failures = 0;
   int txn = 0;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic [W-1:0] bt;
      logic         z;
      logic         o;
      logic         d;
      logic         il;
   } exp_t;

   typedef struct packed {
      logic [W-1:0] sa;
      logic [W-1:0] sb;
      logic [5:0]   ssel;
      logic [W-1:0] simm;
      logic [W-1:0] spc;
   } stim_t;

   exp_t q_exp[$];
   int   q_lat[$];

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .imm(imm), .pc(pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi),
      .zero_flag(zero_flag), .ovf_flag(ovf_flag), .dz_flag(dz_flag),
      .illegal(illegal), .branch_target(branch_target)
   );

   always #5 clk = ~clk;

   function automatic exp_t observed();
      observed = {result, result_hi, branch_target, zero_flag, ovf_flag, dz_flag, illegal};
   endfunction

   // Reference model
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic [5:0] isel, input logic [W-1:0] iimm,
                                  input logic [W-1:0] ipc);
      exp_t e;
      longint s;
      logic [2*W-1:0] p;
      logic [2*W-1:0] ext;
      e = '0;
      e.bt = (iimm * 4) + ipc;
      e.z = (ia == ib);
      case (isel)
         6'd0: begin
            e.res = ia + ib;
            s = longint'($signed(ia)) + longint'($signed(ib));
            e.o = (s > SMAX) || (s < SMIN);
         end
         6'd1: begin
            e.res = ia - ib;
            s = longint'($signed(ia)) - longint'($signed(ib));
            e.o = (s > SMAX) || (s < SMIN);
         end
         6'd2: e.res = ia & ib;
         6'd3: e.res = ia | ib;
         6'd4: e.res = ia << (ib % W);
         6'd5: e.res = ia >> (ib % W);
         6'd6: e.res = (longint'($signed(ia)) < longint'($signed(ib))) ? 1 : 0;
         6'd7: e.res = (ia < ib) ? 1 : 0;
         6'd8: begin
            ext = {{W{ia[W-1]}}, ia} >> (ib % W);
            e.res = ext[W-1:0];
         end
         6'd9:  e.res = ia ^ ib;
         6'd10: e.res = ~(ia | ib);
         6'd11: begin
            p = {{W{1'b0}}, ia} * {{W{1'b0}}, ib};
            e.res = p[W-1:0];
            e.hi = p[2*W-1:W];
         end
         6'd12: begin
            if (ib == 0) begin
               e.res = '1;
               e.hi = ia;
               e.d = 1'b1;
            end else begin
               e.res = ia / ib;
               e.hi = ia % ib;
            end
         end
         6'd63: e.z = 1'b0;
         default: begin
            e.z = 1'b0;
            e.il = 1'b1;
         end
      endcase
      return e;
   endfunction

   function automatic int exp_lat(input logic [5:0] isel, input logic [W-1:0] ib);
      return ((isel == 6'd11) || ((isel == 6'd12) && (ib != 0))) ? W + 1 : 1;
   endfunction

   // Wait (bounded) for in_ready, queue expectation, drive until the accepting edge
   task automatic issue(input stim_t st);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      q_exp.push_back(model(st.sa, st.sb, st.ssel, st.simm, st.spc));
      q_lat.push_back(exp_lat(st.ssel, st.sb));
      a = st.sa; b = st.sb; sel = st.ssel; imm = st.simm; pc = st.spc;
      in_valid = 1'b1;
      @(posedge clk);
   endtask

   // Count cycles from accept to out_valid (bounded)
   task automatic wait_result(output int lat);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (observed() !== exp_t'(0)) begin failures++; $display("FAIL reset_outputs got=%h want=0", observed()); end
      $display("reset: in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
      rst = 1'b0;
   endtask

   task automatic run_table(input string tname, input stim_t tbl[$]);
      int lat;
      exp_t e;
      int el;
      foreach (tbl[i]) begin
         issue(tbl[i]);
         wait_result(lat);
         e = q_exp.pop_front();
         el = q_lat.pop_front();
         checks += 2;
         if (observed() !== e) begin
            failures++;
            $display("FAIL %s[%0d] outputs got=%h want=%h", tname, i, observed(), e);
         end
         if (lat != el) begin
            failures++;
            $display("FAIL %s[%0d] latency got=%0d want=%0d", tname, i, lat, el);
         end
         $display("txn %0d %s sel=%h a=%h b=%h result=%h hi=%h flags zodi=%b%b%b%b bt=%h lat=%0d",
                  txn, tname, tbl[i].ssel, tbl[i].sa, tbl[i].sb, result, result_hi,
                  zero_flag, ovf_flag, dz_flag, illegal, branch_target, lat);
         txn++;
         release_out();
      end
   endtask

   task automatic test_single_cycle();
      stim_t t[$];
      t.push_back({32'h7FFFFFFF, 32'h1, 6'd0, 32'h0, 32'h0});
      t.push_back({32'h80000000, 32'h1, 6'd1, 32'h0, 32'h0});
      t.push_back({32'h5, 32'h5, 6'd1, 32'h0, 32'h0});
      t.push_back({32'hF0F0_1234, 32'h0FF0_FF00, 6'd2, 32'h0, 32'h0});
      t.push_back({32'hF0F0_1234, 32'h0FF0_FF00, 6'd3, 32'h0, 32'h0});
      t.push_back({32'h8000_0001, 32'h21, 6'd4, 32'h0, 32'h0});
      t.push_back({32'h8000_0000, 32'h3F, 6'd5, 32'h0, 32'h0});
      t.push_back({32'h8000_0000, 32'h24, 6'd8, 32'h0, 32'h0});
      t.push_back({32'hFFFFFFFF, 32'h1, 6'd6, 32'h0, 32'h0});
      t.push_back({32'hFFFFFFFF, 32'h1, 6'd7, 32'h0, 32'h0});
      t.push_back({32'hA5A5_A5A5, 32'h0F0F_0F0F, 6'd9, 32'h0, 32'h0});
      t.push_back({32'hA5A5_0000, 32'h0000_0F0F, 6'd10, 32'h0, 32'h0});
      t.push_back({32'h9, 32'h9, 6'd63, 32'h3, 32'h100});
      t.push_back({32'h9, 32'h9, 6'h3E, 32'h3, 32'h100});
      t.push_back({32'h5, 32'h0, 6'd12, 32'hFFFFFFFF, 32'h10});
      run_table("single", t);
   endtask

   task automatic test_multi_cycle();
      stim_t t[$];
      t.push_back({32'hFFFFFFFF, 32'h2, 6'd11, 32'h1, 32'h0});
      t.push_back({32'd100, 32'd7, 6'd12, 32'h0, 32'h0});
      t.push_back({32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 32'h0, 32'h0});
      t.push_back({32'd3, 32'd10, 6'd12, 32'h0, 32'h0});
      t.push_back({$urandom(), $urandom(), 6'd11, 32'h0, 32'h0});
      t.push_back({$urandom(), 32'h0000_0000 | $urandom_range(1, 65535), 6'd12, 32'h0, 32'h0});
      run_table("multi", t);
   endtask

   task automatic test_hold();
      int lat;
      exp_t e;
      stim_t st;
      st = {32'h1234_5678, 32'h1111_1111, 6'd9, 32'h40, 32'h8};
      issue(st);
      wait_result(lat);
      e = q_exp.pop_front();
      void'(q_lat.pop_front());
      a = 32'hDEAD_BEEF; b = 32'h1; sel = 6'd0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks += 2;
         if (observed() !== e) begin failures++; $display("FAIL hold[%0d] outputs got=%h want=%h", i, observed(), e); end
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold[%0d] handshake got valid=%b ready=%b want valid=1 ready=0", i, out_valid, in_ready);
         end
         $display("hold cycle %0d: out_valid=%b in_ready=%b result=%h", i, out_valid, in_ready, result);
         @(negedge clk);
      end
      in_valid = 1'b0;
      release_out();
   endtask

   task automatic test_reset_busy();
      stim_t st;
      st = {32'hFFFFFFFF, 32'h3, 6'd11, 32'h7, 32'h20};
      issue(st);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      void'(q_exp.pop_front());
      void'(q_lat.pop_front());
      checks += 3;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_busy in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_busy out_valid got=%b want=0", out_valid); end
      if (observed() !== exp_t'(0)) begin failures++; $display("FAIL rst_busy outputs got=%h want=0", observed()); end
      $display("reset mid-busy: in_ready=%b out_valid=%b result=%h bt=%h", in_ready, out_valid, result, branch_target);
      // Nothing from the discarded op may appear later
      repeat (40) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_busy stale_result got=%b want=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      int n_out;
      int r;
      exp_t e;
      n_out = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            e = q_exp.pop_front();
            void'(q_lat.pop_front());
            n_out++;
            checks++;
            if (observed() !== e) begin
               failures++;
               $display("FAIL b2b[%0d] outputs got=%h want=%h", cyc, observed(), e);
            end
            $display("txn %0d b2b result=%h flags zodi=%b%b%b%b", txn, result, zero_flag, ovf_flag, dz_flag, illegal);
            txn++;
         end
         if (in_ready) begin
            r = $urandom_range(0, 13);
            a = $urandom();
            b = (r % 3 == 0) ? a : $urandom();
            imm = $urandom();
            pc = $urandom();
            sel = (r <= 10) ? 6'(r) : (r == 11) ? 6'd63 : (r == 12) ? 6'h3E : 6'd12;
            if (r == 13) b = '0;
            q_exp.push_back(model(a, b, sel, imm, pc));
            q_lat.push_back(1);
            in_valid = 1'b1;
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks += 2;
      if (n_out != 20) begin failures++; $display("FAIL b2b throughput got=%0d results want=20", n_out); end
      if (q_exp.size() != 0) begin failures++; $display("FAIL b2b pending got=%0d want=0", q_exp.size()); end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_multi_cycle();
      test_hold();
      test_reset_busy();
      test_back_to_back();
      test_single_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
